// File: rtl/pipeline_stall_ctrl_if.sv
// Hazard-source inputs and stage-register control outputs of the stall sequencer.
interface pipeline_stall_ctrl_if #(
    parameter int PERF_W = 16
);
    logic              in_idex_memread;
    logic [4:0]        in_idex_rd;
    logic [4:0]        in_ifid_rs1;
    logic [4:0]        in_ifid_rs2;
    logic              in_branch_taken;
    logic              in_mem_req;
    logic              in_mem_ready;
    logic              pcwrite;
    logic              ifidwrite;
    logic              ifidflush;
    logic              controlsel;
    logic              idexwrite;
    logic              exmemwrite;
    logic              memwbbubble;
    logic              out_timeout_err;
    logic [PERF_W-1:0] out_stall_count;

    // Pipeline side: reports hazards, consumes the enables.
    modport master (
        output in_idex_memread, in_idex_rd, in_ifid_rs1, in_ifid_rs2,
               in_branch_taken, in_mem_req, in_mem_ready,
        input  pcwrite, ifidwrite, ifidflush, controlsel, idexwrite,
               exmemwrite, memwbbubble, out_timeout_err, out_stall_count
    );

    // Sequencer side.
    modport slave (
        input  in_idex_memread, in_idex_rd, in_ifid_rs1, in_ifid_rs2,
               in_branch_taken, in_mem_req, in_mem_ready,
        output pcwrite, ifidwrite, ifidflush, controlsel, idexwrite,
               exmemwrite, memwbbubble, out_timeout_err, out_stall_count
    );
endinterface

// File: rtl/pipeline_stall_ctrl.sv
// Stall/flush sequencer for a 5-stage pipeline: merges load-use, memory-wait
// and taken-branch hazards into stage enables, with a memory-wait watchdog
// and a saturating stall-cycle counter.
module pipeline_stall_ctrl #(
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W       = 4,
    parameter int PERF_W      = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    pipeline_stall_ctrl_if.slave  bus
);

    typedef enum logic [1:0] {RUN, WAIT, ERR} state_e;

    localparam logic [CNT_W-1:0]  TIMEOUT  = CNT_W'(MEM_TIMEOUT);
    localparam logic [PERF_W-1:0] PERF_MAX = '1;

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    wait_cnt_q, wait_cnt_d;
    logic                err_q, err_d;
    logic [PERF_W-1:0]   stall_cnt_q, stall_cnt_d;

    logic freeze;
    logic loaduse;
    logic pcwrite, ifidwrite, ifidflush, controlsel;
    logic idexwrite, exmemwrite, memwbbubble;

    function automatic logic [PERF_W-1:0] sat_inc(input logic [PERF_W-1:0] v);
        return (v == PERF_MAX) ? v : v + PERF_W'(1);
    endfunction

    assign freeze  = bus.in_mem_req & ~bus.in_mem_ready;
    assign loaduse = bus.in_idex_memread & (bus.in_idex_rd != 5'd0) &
                     ((bus.in_idex_rd == bus.in_ifid_rs1) |
                      (bus.in_idex_rd == bus.in_ifid_rs2));

    // State, watchdog, sticky error flag and stall counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= RUN;
            wait_cnt_q  <= '0;
            err_q       <= 1'b0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            err_q       <= err_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    // Next state: count consecutive wait cycles, trap into ERR on timeout.
    always_comb begin
        state_d     = state_q;
        wait_cnt_d  = wait_cnt_q;
        err_d       = err_q;
        stall_cnt_d = pcwrite ? stall_cnt_q : sat_inc(stall_cnt_q);
        case (state_q)
            RUN: begin
                if (freeze) begin
                    state_d    = WAIT;
                    wait_cnt_d = CNT_W'(1);
                end
            end
            WAIT: begin
                if (freeze) begin
                    if (wait_cnt_q == TIMEOUT) begin
                        state_d = ERR;
                        err_d   = 1'b1;
                    end else begin
                        wait_cnt_d = wait_cnt_q + CNT_W'(1);
                    end
                end else begin
                    state_d    = RUN;
                    wait_cnt_d = '0;
                end
            end
            ERR: begin
                state_d = ERR;
            end
            default: begin
                state_d    = RUN;
                wait_cnt_d = '0;
            end
        endcase
    end

    // Outputs: reset > ERR > freeze > branch > load-use > normal.
    always_comb begin
        pcwrite     = 1'b1;
        ifidwrite   = 1'b1;
        ifidflush   = 1'b0;
        controlsel  = 1'b0;
        idexwrite   = 1'b1;
        exmemwrite  = 1'b1;
        memwbbubble = 1'b0;
        if (rst) begin
            pcwrite     = 1'b0;
            ifidwrite   = 1'b0;
            idexwrite   = 1'b0;
            exmemwrite  = 1'b0;
            ifidflush   = 1'b1;
            controlsel  = 1'b1;
            memwbbubble = 1'b1;
        end else if (state_q == ERR || freeze) begin
            pcwrite     = 1'b0;
            ifidwrite   = 1'b0;
            idexwrite   = 1'b0;
            exmemwrite  = 1'b0;
            memwbbubble = 1'b1;
        end else if (bus.in_branch_taken) begin
            // The ID instruction is flushed, so a load-use match there is moot.
            ifidflush  = 1'b1;
            controlsel = 1'b1;
        end else if (loaduse) begin
            pcwrite    = 1'b0;
            ifidwrite  = 1'b0;
            controlsel = 1'b1;
        end
    end

    assign bus.pcwrite         = pcwrite;
    assign bus.ifidwrite       = ifidwrite;
    assign bus.ifidflush       = ifidflush;
    assign bus.controlsel      = controlsel;
    assign bus.idexwrite       = idexwrite;
    assign bus.exmemwrite      = exmemwrite;
    assign bus.memwbbubble     = memwbbubble;
    assign bus.out_timeout_err = err_q;
    assign bus.out_stall_count = stall_cnt_q;

endmodule
